ddr_dq_sequencer: RTL and testbench

- Sequences one DDR DQ bank (ODDR + IOBUF per bit, shared tristate control) for fixed BL4 bursts.
- Accepts write/read burst commands via valid/ready. On writes it drives the bank's D0/D1 pairs and tristate control after a programmable write latency. On reads it captures the bank's O0/O1 pairs after a programmable read latency and returns one assembled 4-beat word.
- Sits between the DDR2 command scheduler and the DQ bank instance.

---
 rtl/ddr_pkg.sv | 27 ++
 rtl/ddr_dq_sequencer_if.sv | 37 +++
 rtl/ddr_lat_counter.sv | 34 +++
 rtl/ddr_dq_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ddr_dq_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR DQ bank sequencer.
//   BL      : fixed burst length in beats
//   BEAT_W  : default DQ bits per bank (one beat)
//   BURST_W : default width of a packed 4-beat burst (beat0 in the LSBs)
//   CNT_W   : width of the latency / turnaround down-counter
//   state_t : sequencer states
package ddr_pkg;

    localparam int unsigned BL      = 4;
    localparam int unsigned BEAT_W  = 16;
    localparam int unsigned BURST_W = BL * BEAT_W;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [3:0] {
        IDLE,
        WR_WAIT,
        WR_PRE,
        WR_BEAT0,
        WR_BEAT1,
        RD_WAIT,
        RD_CAP0,
        RD_CAP1,
        RD_DONE,
        TURNAROUND
    } state_t;

endpackage

// File: rtl/ddr_dq_sequencer_if.sv
// Command / read-return / DQ-bank signal bundle for ddr_dq_sequencer.
//   cmd_valid/cmd_ready/cmd_we/cmd_wdata : burst command handshake from the scheduler
//   rd_valid/rd_data                     : assembled 4-beat read return
//   busy                                 : sequencer not idle
//   bank_t/bank_d0/bank_d1               : tristate control and ODDR beat pair to the bank
//   bank_o0/bank_o1                      : captured beat pair from the bank
// slave  = sequencer side, master = scheduler + bank side.
interface ddr_dq_sequencer_if
    import ddr_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = BEAT_W
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_we;
    logic [BL*BANK_WIDTH-1:0]   cmd_wdata;
    logic                       rd_valid;
    logic [BL*BANK_WIDTH-1:0]   rd_data;
    logic                       busy;
    logic                       bank_t;
    logic [BANK_WIDTH-1:0]      bank_d0;
    logic [BANK_WIDTH-1:0]      bank_d1;
    logic [BANK_WIDTH-1:0]      bank_o0;
    logic [BANK_WIDTH-1:0]      bank_o1;

    modport slave (
        input  cmd_valid, cmd_we, cmd_wdata, bank_o0, bank_o1,
        output cmd_ready, rd_valid, rd_data, busy, bank_t, bank_d0, bank_d1
    );

    modport master (
        output cmd_valid, cmd_we, cmd_wdata, bank_o0, bank_o1,
        input  cmd_ready, rd_valid, rd_data, busy, bank_t, bank_d0, bank_d1
    );

endinterface

// File: rtl/ddr_lat_counter.sv
// Loadable saturating down-counter used for the WL/RL wait and the bus turnaround.
//   clk, rst        : clock, async active-high reset
//   i_load          : load i_load_val (has priority over decrement)
//   i_load_val      : number of cycles the caller will spend counting
//   i_dec           : decrement by one, stopping at zero
//   o_zero_nxt_c    : count reaches zero with this cycle's decrement (final counted cycle)
module ddr_lat_counter
    import ddr_pkg::*;
#(
    parameter int unsigned CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero_nxt_c
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_zero_nxt_c = (r_count <= CW'(1));

endmodule

// File: rtl/ddr_dq_sequencer.sv
// BL4 burst sequencer for one DDR DQ bank (ODDR + IOBUF per bit, shared tristate).
//   clk, rst : clock, async active-high reset
//   bus      : ddr_dq_sequencer_if.slave
//              cmd_* in / cmd_ready out : one burst command per accept
//              rd_valid/rd_data out      : one-cycle pulse with the assembled read burst
//              busy out                  : high in every state but IDLE
//              bank_t/bank_d0/bank_d1    : drive side of the bank, registered
//              bank_o0/bank_o1 in        : capture side of the bank
module ddr_dq_sequencer
    import ddr_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = BEAT_W,
    parameter int unsigned WL         = 3,
    parameter int unsigned RL         = 4,
    parameter int unsigned TURN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    ddr_dq_sequencer_if.slave bus
);

    localparam int unsigned DW = BL * BANK_WIDTH;

    state_t                 r_state;
    logic                   r_cmd_ready;
    logic                   r_busy;
    logic                   r_rd_valid;
    logic                   r_bank_t;
    logic [BANK_WIDTH-1:0]  r_d0;
    logic [BANK_WIDTH-1:0]  r_d1;
    logic [BANK_WIDTH-1:0]  r_cap0;
    logic [BANK_WIDTH-1:0]  r_cap1;
    logic [DW-1:0]          r_wdata;
    logic [DW-1:0]          r_rd_data;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_cnt_last;
    logic [CNT_W-1:0]       w_load_val;

    // r_cmd_ready is only ever high in IDLE, so this is the full handshake
    assign w_accept = bus.cmd_valid && r_cmd_ready;

    // Counter control: load the number of cycles to spend in the next counted state
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = (r_state == WR_WAIT) || (r_state == RD_WAIT) || (r_state == TURNAROUND);
        if (w_accept) begin
            w_load     = 1'b1;
            w_load_val = bus.cmd_we ? CNT_W'(WL - 1) : CNT_W'(RL - 1);
        end else if (r_state == WR_BEAT1) begin
            w_load     = 1'b1;
            w_load_val = CNT_W'(TURN);
        end else if (r_state == RD_DONE) begin
            // RD_DONE already leaves the bus idle, so it counts as the first turnaround cycle
            w_load     = 1'b1;
            w_load_val = (TURN > 1) ? CNT_W'(TURN - 1) : '0;
        end
    end

    ddr_lat_counter #(
        .CW (CNT_W)
    ) u_lat_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_val   (w_load_val),
        .i_dec        (w_dec),
        .o_zero_nxt_c (w_cnt_last)
    );

    // Sequencer FSM; every output is set one cycle ahead so it is valid in the named state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_bank_t    <= 1'b1;
            r_d0        <= '0;
            r_d1        <= '0;
            r_cap0      <= '0;
            r_cap1      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_we) begin
                            r_wdata <= bus.cmd_wdata;
                            if (WL == 1) begin
                                r_state  <= WR_PRE;
                                r_bank_t <= 1'b0;
                            end else begin
                                r_state  <= WR_WAIT;
                            end
                        end else if (RL == 1) begin
                            r_state <= RD_CAP0;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (w_cnt_last) begin
                        r_state  <= WR_PRE;
                        r_bank_t <= 1'b0;
                    end
                end
                WR_PRE: begin
                    r_state <= WR_BEAT0;
                    r_d0    <= r_wdata[0*BANK_WIDTH +: BANK_WIDTH];
                    r_d1    <= r_wdata[1*BANK_WIDTH +: BANK_WIDTH];
                end
                WR_BEAT0: begin
                    r_state <= WR_BEAT1;
                    r_d0    <= r_wdata[2*BANK_WIDTH +: BANK_WIDTH];
                    r_d1    <= r_wdata[3*BANK_WIDTH +: BANK_WIDTH];
                end
                WR_BEAT1: begin
                    r_bank_t <= 1'b1;
                    r_d0     <= '0;
                    r_d1     <= '0;
                    if (TURN > 0) begin
                        r_state <= TURNAROUND;
                    end else begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (w_cnt_last) begin
                        r_state <= RD_CAP0;
                    end
                end
                RD_CAP0: begin
                    r_state <= RD_CAP1;
                    r_cap0  <= bus.bank_o0;
                    r_cap1  <= bus.bank_o1;
                end
                RD_CAP1: begin
                    r_state    <= RD_DONE;
                    r_rd_data  <= {bus.bank_o1, bus.bank_o0, r_cap1, r_cap0};
                    r_rd_valid <= 1'b1;
                end
                RD_DONE: begin
                    if (TURN > 1) begin
                        r_state <= TURNAROUND;
                    end else begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                TURNAROUND: begin
                    if (w_cnt_last) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_bank_t <= 1'b1;
                    r_d0     <= '0;
                    r_d1     <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.bank_t    = r_bank_t;
    assign bus.bank_d0   = r_d0;
    assign bus.bank_d1   = r_d1;

endmodule

// File: tb/tb_ddr_dq_sequencer.sv
// Directed bench for ddr_dq_sequencer (W=16, WL=3, RL=4, TURN=1).
// Cycle k = the clock period after the k-th edge following the accept edge; outputs
// are sampled 1 time unit after each rising edge.
module tb_ddr_dq_sequencer;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ddr_dq_sequencer_if #(.BANK_WIDTH(W)) bus ();

    ddr_dq_sequencer #(
        .BANK_WIDTH (W),
        .WL         (3),
        .RL         (4),
        .TURN       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_wdata = '0;
        bus.bank_o0   = '0;
        bus.bank_o1   = '0;
        #2;
        total++; if (bus.bank_t !== 1'b1) begin bad++; $display("FAIL rst_bank_t got=%b exp=1", bus.bank_t); end
        total++; if (bus.bank_d0 !== 16'h0) begin bad++; $display("FAIL rst_d0 got=%h exp=0000", bus.bank_d0); end
        total++; if (bus.bank_d1 !== 16'h0) begin bad++; $display("FAIL rst_d1 got=%h exp=0000", bus.bank_d1); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", bus.rd_valid); end
        total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", bus.rd_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        step();
        step();
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_held got=%b exp=0", bus.cmd_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_release got=%b exp=0", bus.cmd_ready); end
        step();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_write();
        logic        exp_t;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_pre got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_wdata = 64'h4444_3333_2222_1111;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            exp_t  = !(k >= 3 && k <= 5);
            exp_d0 = (k == 4) ? 16'h1111 : (k == 5) ? 16'h3333 : 16'h0000;
            exp_d1 = (k == 4) ? 16'h2222 : (k == 5) ? 16'h4444 : 16'h0000;
            total++; if (bus.bank_t !== exp_t) begin bad++; $display("FAIL wr_bank_t cyc=%0d got=%b exp=%b", k, bus.bank_t, exp_t); end
            total++; if (bus.bank_d0 !== exp_d0) begin bad++; $display("FAIL wr_d0 cyc=%0d got=%h exp=%h", k, bus.bank_d0, exp_d0); end
            total++; if (bus.bank_d1 !== exp_d1) begin bad++; $display("FAIL wr_d1 cyc=%0d got=%h exp=%h", k, bus.bank_d1, exp_d1); end
            total++; if (bus.cmd_ready !== (k == 7)) begin bad++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", k, bus.cmd_ready, (k == 7)); end
            total++; if (bus.busy !== (k < 7)) begin bad++; $display("FAIL wr_busy cyc=%0d got=%b exp=%b", k, bus.busy, (k < 7)); end
            total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_valid cyc=%0d got=%b exp=0", k, bus.rd_valid); end
        end
    endtask

    task automatic test_read();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_pre got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            bus.bank_o0 = (k == 4) ? 16'hAAAA : (k == 5) ? 16'hCCCC : 16'h0F0F;
            bus.bank_o1 = (k == 4) ? 16'hBBBB : (k == 5) ? 16'hDDDD : 16'hF0F0;
            total++; if (bus.bank_t !== 1'b1) begin bad++; $display("FAIL rd_bank_t cyc=%0d got=%b exp=1", k, bus.bank_t); end
            total++; if (bus.rd_valid !== (k == 6)) begin bad++; $display("FAIL rd_valid cyc=%0d got=%b exp=%b", k, bus.rd_valid, (k == 6)); end
            total++; if (bus.cmd_ready !== (k == 7)) begin bad++; $display("FAIL rd_ready cyc=%0d got=%b exp=%b", k, bus.cmd_ready, (k == 7)); end
            if (k == 5) begin
                total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL rd_data_early got=%h exp=0", bus.rd_data); end
            end
            if (k >= 6) begin
                total++; if (bus.rd_data !== 64'hDDDD_CCCC_BBBB_AAAA) begin bad++; $display("FAIL rd_data cyc=%0d got=%h exp=ddddccccbbbbaaaa", k, bus.rd_data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_t;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_pre got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_wdata = 64'h8888_7777_6666_5555;
        step();
        bus.cmd_we = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) step();
            if (k == 8) bus.cmd_valid = 1'b0;
            bus.bank_o0 = (k == 11) ? 16'h1234 : (k == 12) ? 16'h9ABC : 16'h0F0F;
            bus.bank_o1 = (k == 11) ? 16'h5678 : (k == 12) ? 16'hDEF0 : 16'hF0F0;
            exp_t = !(k >= 3 && k <= 5);
            total++; if (bus.bank_t !== exp_t) begin bad++; $display("FAIL b2b_bank_t cyc=%0d got=%b exp=%b", k, bus.bank_t, exp_t); end
            total++; if (bus.cmd_ready !== (k == 7 || k == 14)) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", k, bus.cmd_ready, (k == 7 || k == 14)); end
            total++; if (bus.rd_valid !== (k == 13)) begin bad++; $display("FAIL b2b_rd_valid cyc=%0d got=%b exp=%b", k, bus.rd_valid, (k == 13)); end
            if (k == 4) begin
                total++; if (bus.bank_d0 !== 16'h5555) begin bad++; $display("FAIL b2b_d0 got=%h exp=5555", bus.bank_d0); end
            end
            if (k == 13) begin
                total++; if (bus.rd_data !== 64'hDEF0_9ABC_5678_1234) begin bad++; $display("FAIL b2b_rd_data got=%h exp=def09abc56781234", bus.rd_data); end
            end
        end
    endtask

    task automatic test_reset_write();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstw_ready_pre got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_wdata = 64'h0004_0003_0002_A5A5;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        total++; if (bus.bank_d0 !== 16'hA5A5) begin bad++; $display("FAIL rstw_d0_pre got=%h exp=a5a5", bus.bank_d0); end
        rst = 1'b1;
        #1;
        total++; if (bus.bank_t !== 1'b1) begin bad++; $display("FAIL rstw_bank_t got=%b exp=1", bus.bank_t); end
        total++; if (bus.bank_d0 !== 16'h0) begin bad++; $display("FAIL rstw_d0 got=%h exp=0000", bus.bank_d0); end
        total++; if (bus.bank_d1 !== 16'h0) begin bad++; $display("FAIL rstw_d1 got=%h exp=0000", bus.bank_d1); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rstw_ready got=%b exp=0", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstw_busy got=%b exp=0", bus.busy); end
        #1;
        rst = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstw_ready_after i=%0d got=%b exp=1", k, bus.cmd_ready); end
            total++; if (bus.bank_t !== 1'b1) begin bad++; $display("FAIL rstw_bank_t_after i=%0d got=%b exp=1", k, bus.bank_t); end
            total++; if (bus.bank_d0 !== 16'h0) begin bad++; $display("FAIL rstw_d0_after i=%0d got=%h exp=0000", k, bus.bank_d0); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstw_busy_after i=%0d got=%b exp=0", k, bus.busy); end
        end
    endtask

    task automatic test_reset_read();
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            bus.bank_o0 = (k == 4) ? 16'h1111 : 16'h3333;
            bus.bank_o1 = (k == 4) ? 16'h2222 : 16'h4444;
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rstr_rd_valid i=%0d got=%b exp=0", k, bus.rd_valid); end
            total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL rstr_rd_data i=%0d got=%h exp=0", k, bus.rd_data); end
            total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstr_ready i=%0d got=%b exp=1", k, bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            bus.bank_o0 = (k == 4) ? 16'h0102 : (k == 5) ? 16'h0506 : 16'h0F0F;
            bus.bank_o1 = (k == 4) ? 16'h0304 : (k == 5) ? 16'h0708 : 16'hF0F0;
            total++; if (bus.rd_valid !== (k == 6)) begin bad++; $display("FAIL rstr_next_valid cyc=%0d got=%b exp=%b", k, bus.rd_valid, (k == 6)); end
            if (k == 6) begin
                total++; if (bus.rd_data !== 64'h0708_0506_0304_0102) begin bad++; $display("FAIL rstr_next_data got=%h exp=0708050603040102", bus.rd_data); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic        exp_t;
        logic [15:0] exp_d0;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL ign_ready_pre got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_wdata = 64'h1357_2468_ACE0_BDF1;
        step();
        bus.cmd_we    = 1'b0;
        bus.cmd_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            if (k == 6) bus.cmd_valid = 1'b0;
            exp_t  = !(k >= 3 && k <= 5);
            exp_d0 = (k == 4) ? 16'hBDF1 : (k == 5) ? 16'h2468 : 16'h0000;
            total++; if (bus.bank_t !== exp_t) begin bad++; $display("FAIL ign_bank_t cyc=%0d got=%b exp=%b", k, bus.bank_t, exp_t); end
            total++; if (bus.bank_d0 !== exp_d0) begin bad++; $display("FAIL ign_d0 cyc=%0d got=%h exp=%h", k, bus.bank_d0, exp_d0); end
            total++; if (bus.cmd_ready !== (k >= 7)) begin bad++; $display("FAIL ign_ready cyc=%0d got=%b exp=%b", k, bus.cmd_ready, (k >= 7)); end
            total++; if (bus.busy !== (k < 7)) begin bad++; $display("FAIL ign_busy cyc=%0d got=%b exp=%b", k, bus.busy, (k < 7)); end
            total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL ign_rd_valid cyc=%0d got=%b exp=0", k, bus.rd_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_write();
        test_reset_read();
        test_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
